// File: rtl/cactus_scheduler.sv
// Cactus obstacle scheduler for the dino game.
// Spawns cacti at the right screen edge, scrolls them left by the game speed on every
// frame tick, retires them at the left edge and paces spawns with a randomised gap counter.
// Optional feature: define CACTUS_SCORE_EN to add a saturating 16-bit score output that
// counts cacti retired at the left edge.
module cactus_scheduler #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned X_WIDTH   = 10,
  parameter int unsigned SCREEN_X  = 640,
  parameter int unsigned MIN_GAP   = 160,
  parameter int unsigned GAP_SHIFT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         tick,
  input  logic                         collide,
  input  logic [3:0]                   speed,
  input  logic [4:0]                   random,
  output logic                         rng_step,
  output logic                         spawn_pulse,
  output logic [NUM_SLOTS-1:0]         cactus_valid,
  output logic [NUM_SLOTS*X_WIDTH-1:0] cactus_x,
  output logic [NUM_SLOTS*2-1:0]       cactus_type,
`ifdef CACTUS_SCORE_EN
  output logic [15:0]                  score,
`endif
  output logic [1:0]                   state
);

  localparam int unsigned GapMax = MIN_GAP + (7 << GAP_SHIFT);
  localparam int unsigned GapW   = $clog2(GapMax + 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } state_e;

  state_e                             state_q, state_d;
  logic [NUM_SLOTS-1:0]               valid_q, valid_d;
  logic [NUM_SLOTS-1:0][X_WIDTH-1:0]  x_q, x_d;
  logic [NUM_SLOTS-1:0][1:0]          type_q, type_d;
  logic [GapW-1:0]                    gap_q, gap_d;
  logic                               spawn_q, spawn_d;

  logic [NUM_SLOTS-1:0]               spawn_sel;
  logic                               free_found;
  logic [X_WIDTH-1:0]                 speed_x;
  logic [GapW-1:0]                    speed_g;
  logic [GapW-1:0]                    gap_reload;
  logic [X_WIDTH-1:0]                 spawn_x;

`ifdef CACTUS_SCORE_EN
  logic [15:0]                        score_q, score_d;
  logic [3:0]                         retired;
  logic [16:0]                        score_sum;
`endif

  assign speed_x    = X_WIDTH'(speed);
  assign speed_g    = GapW'(speed);
  assign gap_reload = GapW'(MIN_GAP + (32'(random[4:2]) << GAP_SHIFT));
  assign spawn_x    = X_WIDTH'(SCREEN_X - 1);

  // Next-state: run control, per-tick scroll/retire, spawn decision and gap pacing
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    x_d        = x_q;
    type_d     = type_q;
    gap_d      = gap_q;
    spawn_d    = 1'b0;
    spawn_sel  = '0;
    free_found = 1'b0;
`ifdef CACTUS_SCORE_EN
    score_d    = score_q;
    retired    = '0;
    score_sum  = '0;
`endif

    // Lowest-index slot that is free before the tick; slots freed by this tick's move
    // only become eligible on the next tick.
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (!valid_q[i] && !free_found) begin
        spawn_sel[i] = 1'b1;
        free_found   = 1'b1;
      end
    end

    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          state_d = StRun;
          valid_d = '0;
          x_d     = '0;
          type_d  = '0;
          gap_d   = GapW'(MIN_GAP);
`ifdef CACTUS_SCORE_EN
          score_d = '0;
`endif
        end
      end
      StRun: begin
        if (collide) begin
          // Collision wins over a simultaneous tick: freeze everything as it is.
          state_d = StHalt;
        end else if (tick) begin
          for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (valid_q[i]) begin
              if (x_q[i] < speed_x) begin
                valid_d[i] = 1'b0;
                x_d[i]     = '0;
`ifdef CACTUS_SCORE_EN
                retired    = retired + 4'd1;
`endif
              end else begin
                x_d[i] = x_q[i] - speed_x;
              end
            end
          end

          if ((gap_q == '0) && free_found) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
              if (spawn_sel[i]) begin
                valid_d[i] = 1'b1;
                x_d[i]     = spawn_x;
                type_d[i]  = random[1:0];
              end
            end
            gap_d   = gap_reload;
            spawn_d = 1'b1;
          end else if (gap_q < speed_g) begin
            // Also holds the counter at zero while every slot is occupied.
            gap_d = '0;
          end else begin
            gap_d = gap_q - speed_g;
          end

`ifdef CACTUS_SCORE_EN
          score_sum = {1'b0, score_q} + 17'(retired);
          score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      valid_q <= '0;
      x_q     <= '0;
      type_q  <= '0;
      gap_q   <= '0;
      spawn_q <= 1'b0;
`ifdef CACTUS_SCORE_EN
      score_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      type_q  <= type_d;
      gap_q   <= gap_d;
      spawn_q <= spawn_d;
`ifdef CACTUS_SCORE_EN
      score_q <= score_d;
`endif
    end
  end

  // LFSR step: stir continuously while idle, otherwise advance once per consumed value
  always_comb begin
    rng_step = 1'b0;
    unique case (state_q)
      StIdle:  rng_step = 1'b1;
      StRun:   rng_step = spawn_q;
      default: rng_step = 1'b0;
    endcase
  end

  assign spawn_pulse  = spawn_q;
  assign cactus_valid = valid_q;
  assign cactus_x     = x_q;
  assign cactus_type  = type_q;
  assign state        = state_q;
`ifdef CACTUS_SCORE_EN
  assign score        = score_q;
`endif

endmodule

// File: tb/tb_cactus_scheduler.sv
// Self-checking bench for cactus_scheduler: a behavioural slot model feeds an expected-result
// queue on every driven cycle; results are popped and compared after the clock edge.
module tb_cactus_scheduler;

  localparam int NS = 4;
  localparam int XW = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             tick = 1'b0;
  logic             collide = 1'b0;
  logic [3:0]       speed = 4'd0;
  logic [4:0]       random = 5'd0;
  logic             rng_step;
  logic             spawn_pulse;
  logic [NS-1:0]    cactus_valid;
  logic [NS*XW-1:0] cactus_x;
  logic [NS*2-1:0]  cactus_type;
  logic [1:0]       state;
`ifdef CACTUS_SCORE_EN
  logic [15:0]      score;
`endif

  cactus_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .tick         (tick),
    .collide      (collide),
    .speed        (speed),
    .random       (random),
    .rng_step     (rng_step),
    .spawn_pulse  (spawn_pulse),
    .cactus_valid (cactus_valid),
    .cactus_x     (cactus_x),
    .cactus_type  (cactus_type),
`ifdef CACTUS_SCORE_EN
    .score        (score),
`endif
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       st;
    logic [NS-1:0]    v;
    logic [NS*XW-1:0] x;
    logic [NS*2-1:0]  ty;
    logic             sp;
    logic             rs;
    logic [15:0]      sc;
  } snap_t;

  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Reference model
  int m_st, m_gap, m_sc, m_last;
  bit m_sp;
  bit m_v[NS];
  int m_x[NS];
  int m_ty[NS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_v[i]  = 1'b0;
      m_x[i]  = 0;
      m_ty[i] = 0;
    end
  endtask

  task automatic model_step(input bit r, input bit t, input bit c, input bit s);
    int free;
    int spd;
    free = -1;
    spd  = int'(speed);
    if (r) begin
      m_st = 0; m_gap = 0; m_sp = 1'b0; m_sc = 0;
      model_clear();
      return;
    end
    m_sp = 1'b0;
    if (m_st == 0 || m_st == 2) begin
      if (s) begin
        m_st = 1; m_gap = 160; m_sc = 0;
        model_clear();
      end
    end else if (m_st == 1) begin
      if (c) begin
        m_st = 2;
      end else if (t) begin
        for (int i = NS - 1; i >= 0; i--) if (!m_v[i]) free = i;
        for (int i = 0; i < NS; i++) begin
          if (m_v[i]) begin
            if (m_x[i] < spd) begin
              m_v[i] = 1'b0;
              m_x[i] = 0;
              if (m_sc < 65535) m_sc++;
            end else begin
              m_x[i] -= spd;
            end
          end
        end
        if (m_gap == 0 && free >= 0) begin
          m_v[free]  = 1'b1;
          m_x[free]  = 639;
          m_ty[free] = int'(random) & 3;
          m_gap      = 160 + ((int'(random) >> 2) * 16);
          m_sp       = 1'b1;
          m_last     = free;
        end else begin
          m_gap = (m_gap > spd) ? m_gap - spd : 0;
        end
      end
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.st = 2'(m_st);
    for (int i = 0; i < NS; i++) begin
      s.v[i]             = m_v[i];
      s.x[i*XW +: XW]    = XW'(m_x[i]);
      s.ty[i*2 +: 2]     = 2'(m_ty[i]);
    end
    s.sp = m_sp;
    s.rs = (m_st == 0) ? 1'b1 : (m_st == 1) ? m_sp : 1'b0;
    s.sc = 16'(m_sc);
    return s;
  endfunction

  // One clock cycle of stimulus; expectation queued when driven, compared after the edge.
  task automatic cyc(input bit r, input bit t, input bit c, input bit s);
    snap_t e;
    rst = r; tick = t; collide = c; start = s;
    model_step(r, t, c, s);
    exp_q.push_back(model_snap());
    @(posedge clk);
    #1;
    rst = 1'b0; tick = 1'b0; collide = 1'b0; start = 1'b0;
    e = exp_q.pop_front();
    check("state", 64'(state), 64'(e.st));
    check("valid", 64'(cactus_valid), 64'(e.v));
    check("x", 64'(cactus_x), 64'(e.x));
    check("type", 64'(cactus_type), 64'(e.ty));
    check("spawn_pulse", 64'(spawn_pulse), 64'(e.sp));
    check("rng_step", 64'(rng_step), 64'(e.rs));
`ifdef CACTUS_SCORE_EN
    check("score", 64'(score), 64'(e.sc));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nsp, t1, t2, k;

    // Reset state
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("rst_state", 64'(state), 64'd0);
    check("rst_valid", 64'(cactus_valid), 64'd0);
    check("rst_x", 64'(cactus_x), 64'd0);
    check("rst_rng_step", 64'(rng_step), 64'd1);

    // Spawn timing: 40 quiet ticks, spawn on tick 41
    speed = 4'd4;
    random = 5'b00001;
    cyc(0, 0, 0, 1);
    check("t1_run", 64'(state), 64'd1);
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
    cyc(0, 1, 0, 0);
    check("t1_spawn", 64'(spawn_pulse), 64'd1);
    check("t1_valid0", 64'(cactus_valid[0]), 64'd1);
    check("t1_x0", 64'(cactus_x[XW-1:0]), 64'd639);
    check("t1_type0", 64'(cactus_type[1:0]), 64'd1);
    check("t1_rng_step", 64'(rng_step), 64'd1);

    // Scroll and retire; start while running is ignored
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 159; i++) cyc(0, 1, 0, 0);
    check("t2_x0", 64'(cactus_x[XW-1:0]), 64'd3);
    check("t2_valid0", 64'(cactus_valid[0]), 64'd1);
    cyc(0, 1, 0, 0);
    check("t2_retired", 64'(cactus_valid[0]), 64'd0);
    check("t2_x0_zero", 64'(cactus_x[XW-1:0]), 64'd0);
`ifdef CACTUS_SCORE_EN
    check("t2_score", 64'(score), 64'd1);
`endif

    // Random gap and type: gap 272 at speed 15 gives a 20-tick spawn interval
    cyc(1, 0, 0, 0);
    speed = 4'd15;
    random = 5'b11110;
    cyc(0, 0, 0, 1);
    nsp = 0; t1 = 0; t2 = 0;
    for (k = 1; k <= 200 && nsp < 2; k++) begin
      cyc(0, 1, 0, 0);
      if (m_sp) begin
        nsp++;
        check("t3_type", 64'(cactus_type[2*m_last +: 2]), 64'd2);
        if (nsp == 1) t1 = k;
        else t2 = k;
      end
    end
    check("t3_spawn_count", 64'(nsp), 64'd2);
    check("t3_first_tick", 64'(t1), 64'd12);
    check("t3_interval", 64'(t2 - t1), 64'd20);

    // Fill all slots (spawns taken on frozen ticks), then refill slot0 after it ages out
    cyc(1, 0, 0, 0);
    random = 5'b00001;
    cyc(0, 0, 0, 1);
    nsp = 0;
    for (k = 0; k < 4000 && nsp < 4; k++) begin
      speed = (m_gap == 0) ? 4'd0 : 4'd1;
      cyc(0, 1, 0, 0);
      if (m_sp) nsp++;
    end
    check("t3b_spawn_count", 64'(nsp), 64'd4);
    check("t3b_full", 64'(cactus_valid), 64'hF);
    check("t3b_x0", 64'(cactus_x[XW-1:0]), 64'd159);
    speed = 4'd1;
    for (k = 0; k < 400 && m_v[0]; k++) cyc(0, 1, 0, 0);
    check("t3b_freed", 64'(cactus_valid[0]), 64'd0);
    check("t3b_no_spawn_on_free", 64'(spawn_pulse), 64'd0);
    cyc(0, 1, 0, 0);
    check("t3b_respawn", 64'(spawn_pulse), 64'd1);
    check("t3b_refull", 64'(cactus_valid), 64'hF);
    check("t3b_x0_spawn", 64'(cactus_x[XW-1:0]), 64'd639);

    // Collide beats tick; HALT is frozen
    cyc(0, 1, 1, 0);
    check("t4_halt", 64'(state), 64'd2);
    check("t4_no_spawn", 64'(spawn_pulse), 64'd0);
    check("t4_rng_step", 64'(rng_step), 64'd0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    check("t4_still_halt", 64'(state), 64'd2);

    // Restart from HALT, then reset mid-run
    cyc(0, 0, 0, 1);
    check("t5_run", 64'(state), 64'd1);
    check("t5_cleared", 64'(cactus_valid), 64'd0);
    speed = 4'd4;
    for (int i = 0; i < 45; i++) cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    check("t5_rst_state", 64'(state), 64'd0);
    check("t5_rst_valid", 64'(cactus_valid), 64'd0);
    check("t5_rst_x", 64'(cactus_x), 64'd0);
    check("t5_rst_type", 64'(cactus_type), 64'd0);
    check("t5_rst_rng_step", 64'(rng_step), 64'd1);
    cyc(0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
